// File: rtl/fp_normalize_pack.sv
// Normalize, round and pack a raw mantissa sum into a 1/4/4 float (bias 7).
// FP_ROUND_EN selects round-to-nearest-even; left undefined the fraction is truncated.
module fp_normalize_pack (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_sign,
  input  logic [3:0] in_exp,
  input  logic [6:0] in_mant,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sign,
  output logic [3:0] out_exp,
  output logic [3:0] out_fract,
  output logic       out_zero,
  output logic       out_overflow
);

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t     state, state_nxt;
  logic       sign_r, sign_nxt;
  logic [3:0] exp_r, exp_nxt;
  logic [6:0] mant_r, mant_nxt;
  logic       sticky_r, sticky_nxt;

  logic       res_sign_nxt, res_zero_nxt, res_ovf_nxt;
  logic [3:0] res_exp_nxt, res_fract_nxt;

  logic [6:0] mant_n;
  logic       sticky_n;
  logic [4:0] exp_n;
  logic       round_inc;
  logic [4:0] fract_rnd;
  logic [4:0] exp_fin;

  // Carry renormalization, rounding and round-carry are evaluated every cycle;
  // NORM only commits them once the hidden bit sits in position 5.
  always_comb begin
    mant_n   = mant_r;
    sticky_n = sticky_r;
    exp_n    = {1'b0, exp_r};
    if (mant_r[6]) begin
      mant_n   = {1'b0, mant_r[6:1]};
      sticky_n = sticky_r | mant_r[0];
      exp_n    = exp_n + 5'd1;
    end
`ifdef FP_ROUND_EN
    round_inc = mant_n[0] & (sticky_n | mant_n[1]);
`else
    round_inc = 1'b0;
`endif
    fract_rnd = {1'b0, mant_n[4:1]} + {4'd0, round_inc};
    exp_fin   = exp_n + {4'd0, fract_rnd[4]};
  end

  always_comb begin
    state_nxt     = state;
    sign_nxt      = sign_r;
    exp_nxt       = exp_r;
    mant_nxt      = mant_r;
    sticky_nxt    = sticky_r;
    res_sign_nxt  = out_sign;
    res_exp_nxt   = out_exp;
    res_fract_nxt = out_fract;
    res_zero_nxt  = out_zero;
    res_ovf_nxt   = out_overflow;
    case (state)
      IDLE: begin
        if (in_valid) begin
          sign_nxt   = in_sign;
          exp_nxt    = in_exp;
          mant_nxt   = in_mant;
          sticky_nxt = 1'b0;
          state_nxt  = NORM;
        end
      end
      NORM: begin
        if (mant_r == '0 || exp_r == '0) begin
          res_sign_nxt  = 1'b0;
          res_exp_nxt   = '0;
          res_fract_nxt = '0;
          res_zero_nxt  = 1'b1;
          res_ovf_nxt   = 1'b0;
          state_nxt     = DONE;
        end else if (mant_r[6:5] == 2'b00) begin
          mant_nxt = {mant_r[5:0], 1'b0};
          exp_nxt  = exp_r - 4'd1;
        end else begin
          mant_nxt     = mant_n;
          sticky_nxt   = sticky_n;
          res_sign_nxt = sign_r;
          res_zero_nxt = 1'b0;
          if (exp_fin >= 5'd15) begin
            res_exp_nxt   = 4'd15;
            res_fract_nxt = '0;
            res_ovf_nxt   = 1'b1;
          end else begin
            res_exp_nxt   = exp_fin[3:0];
            res_fract_nxt = fract_rnd[3:0];
            res_ovf_nxt   = 1'b0;
          end
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      sign_r       <= 1'b0;
      exp_r        <= '0;
      mant_r       <= '0;
      sticky_r     <= 1'b0;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_sign     <= 1'b0;
      out_exp      <= '0;
      out_fract    <= '0;
      out_zero     <= 1'b0;
      out_overflow <= 1'b0;
    end else begin
      state        <= state_nxt;
      sign_r       <= sign_nxt;
      exp_r        <= exp_nxt;
      mant_r       <= mant_nxt;
      sticky_r     <= sticky_nxt;
      in_ready     <= (state_nxt == IDLE);
      out_valid    <= (state_nxt == DONE);
      out_sign     <= res_sign_nxt;
      out_exp      <= res_exp_nxt;
      out_fract    <= res_fract_nxt;
      out_zero     <= res_zero_nxt;
      out_overflow <= res_ovf_nxt;
    end
  end

endmodule

// File: tb/tb_fp_normalize_pack.sv
// Scoreboard bench for fp_normalize_pack: directed vectors push expectations,
// a negedge monitor pops and checks result, latency and hold stability.
module tb_fp_normalize_pack;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_sign = 1'b0;
  logic [3:0] in_exp = '0;
  logic [6:0] in_mant = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_sign;
  logic [3:0] out_exp;
  logic [3:0] out_fract;
  logic       out_zero;
  logic       out_overflow;

`ifdef FP_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  fp_normalize_pack dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exp(out_exp), .out_fract(out_fract),
    .out_zero(out_zero), .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] res;   // {sign, exp, fract, zero, overflow}
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  bit   seen = 1'b0;
  bit   cur_ok = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: first cycle of out_valid pops the scoreboard; later held cycles must not change.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !seen) begin
        seen = 1'b1;
        if (sb.size() == 0) begin
          cur_ok = 1'b0;
          tests++;
          fails++;
          $display("FAIL unexpected_output: got result %0h with empty scoreboard",
                   {out_sign, out_exp, out_fract, out_zero, out_overflow});
        end else begin
          cur = sb.pop_front();
          cur_ok = 1'b1;
          chk("result", {21'd0, out_sign, out_exp, out_fract, out_zero, out_overflow}, {21'd0, cur.res});
          chk("latency", cyc - cur.acc, cur.lat);
        end
      end else if (out_valid && seen && cur_ok) begin
        chk("hold_result", {21'd0, out_sign, out_exp, out_fract, out_zero, out_overflow}, {21'd0, cur.res});
        chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      end
      if (!out_valid) seen = 1'b0;
    end
  end

  task automatic send(input logic s, input logic [3:0] e, input logic [6:0] m,
                      input logic [10:0] res, input int lat, input bit push);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: in_ready got 0, expected 1");
      in_valid = 1'b0;
      return;
    end
    if (push) sb.push_back('{res: res, lat: lat, acc: cyc});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    bit bad;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {26'd0, out_valid, out_sign, out_exp == 4'd0, out_fract == 4'd0, out_zero, out_overflow},
        {26'd0, 6'b001100});
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;

    //   sign  exp    mant         {s, exp,   fract,  z, o}                         latency
    send(1'b0, 4'd7,  7'b0110100, {1'b0, 4'd7,  4'b1010, 2'b00}, 2, 1);
    send(1'b0, 4'd7,  7'b1010110, {1'b0, 4'd8,  RND ? 4'b0110 : 4'b0101, 2'b00}, 2, 1);
    send(1'b1, 4'd5,  7'b0000000, {1'b0, 4'd0,  4'b0000, 2'b10}, 2, 1);
    send(1'b0, 4'd6,  7'b0000110, {1'b0, 4'd3,  4'b1000, 2'b00}, 5, 1);
    send(1'b0, 4'd2,  7'b0000100, {1'b0, 4'd0,  4'b0000, 2'b10}, 4, 1);
    send(1'b0, 4'd14, 7'b1000000, {1'b0, 4'd15, 4'b0000, 2'b01}, 2, 1);
    send(1'b1, 4'd14, 7'b1100000, {1'b1, 4'd15, 4'b0000, 2'b01}, 2, 1);
    send(1'b0, 4'd3,  7'b0111111, RND ? {1'b0, 4'd4, 4'b0000, 2'b00} : {1'b0, 4'd3, 4'b1111, 2'b00}, 2, 1);
    send(1'b1, 4'd4,  7'b1011011, {1'b1, 4'd5,  RND ? 4'b0111 : 4'b0110, 2'b00}, 2, 1);
    send(1'b0, 4'd9,  7'b0110101, {1'b0, 4'd9,  4'b1010, 2'b00}, 2, 1);
    send(1'b0, 4'd10, 7'b0000001, {1'b0, 4'd5,  4'b0000, 2'b00}, 7, 1);
    send(1'b1, 4'd0,  7'b0110000, {1'b0, 4'd0,  4'b0000, 2'b10}, 2, 1);
    send(1'b0, 4'd14, 7'b0111111, RND ? {1'b0, 4'd15, 4'b0000, 2'b01} : {1'b0, 4'd14, 4'b1111, 2'b00}, 2, 1);
    drain();

    // Backpressure: hold out_ready low while offering ignored input.
    out_ready = 1'b0;
    send(1'b1, 4'd7, 7'b0101000, {1'b1, 4'd7, 4'b0100, 2'b00}, 2, 1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b1; in_sign = 1'b0; in_exp = 4'd1; in_mant = 7'b0110000;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    drain();

    // Reset while in NORM discards the pending result.
    send(1'b0, 4'd6, 7'b0000110, 11'd0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    bad = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) bad = 1'b1;
    end
    chk("rst_mid_no_valid", {31'd0, bad}, 32'd0);

    // Accepted cleanly after the aborted transaction.
    send(1'b0, 4'd7, 7'b0110100, {1'b0, 4'd7, 4'b1010, 2'b00}, 2, 1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
